// File: rtl/histo_frame_sequencer.sv
// Frame scheduler for the histogram engine: gates frame/line valid, decimates, bounds runs, waits for readout.
// Optional readout watchdog with timeout_flag port when HISTO_SEQ_TIMEOUT_EN is defined.
module histo_frame_sequencer #(
  parameter int DECIM_W = 8,
  parameter int COUNT_W = 16
`ifdef HISTO_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 2000000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_valid,
  input  logic               line_valid,
  input  logic               cfg_enable,
  input  logic [DECIM_W-1:0] cfg_decimate,
  input  logic [COUNT_W-1:0] cfg_num_frames,
  input  logic               readout_done,
  output logic               histo_frame_valid,
  output logic               histo_line_valid,
  output logic [7:0]         capture_id,
  output logic [COUNT_W-1:0] captured_count,
  output logic [COUNT_W-1:0] skipped_count,
  output logic [COUNT_W-1:0] overrun_count,
  output logic               busy,
  output logic               run_done
`ifdef HISTO_SEQ_TIMEOUT_EN
  ,
  output logic               timeout_flag
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CAPTURE,
    S_READOUT,
    S_DONE
  } state_t;

  localparam logic [DECIM_W-1:0] ONE_D = DECIM_W'(1);
  localparam logic [COUNT_W-1:0] ONE_C = COUNT_W'(1);

  state_t             state, state_nxt;
  logic               fv_q;
  logic [7:0]         frame_id;
  logic [7:0]         frame_id_inc;
  logic [DECIM_W-1:0] skip_cnt;
  logic               sof, eof;
  logic               gate, clr_run, start_cap, skip_dec;
  logic               inc_skip, inc_cap, inc_ovr;
`ifdef HISTO_SEQ_TIMEOUT_EN
  logic [31:0]        wd_cnt;
  logic               timeout_fire;
`endif

  // Edges are taken against the registered copy so gating can open in the SOF cycle itself.
  assign sof          = frame_valid & ~fv_q;
  assign eof          = ~frame_valid & fv_q;
  assign frame_id_inc = frame_id + 8'd1;
  assign busy         = (state == S_CAPTURE) || (state == S_READOUT);
  assign run_done     = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    gate      = 1'b0;
    clr_run   = 1'b0;
    start_cap = 1'b0;
    skip_dec  = 1'b0;
    inc_skip  = 1'b0;
    inc_cap   = 1'b0;
    inc_ovr   = 1'b0;
`ifdef HISTO_SEQ_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (cfg_enable) begin
          state_nxt = S_WAIT_SOF;
          clr_run   = 1'b1;
        end
      end
      S_WAIT_SOF: begin
        if (!cfg_enable) begin
          state_nxt = S_IDLE;
        end else if (sof) begin
          if (skip_cnt == '0) begin
            start_cap = 1'b1;
            gate      = 1'b1;
            state_nxt = S_CAPTURE;
          end else begin
            skip_dec = 1'b1;
            inc_skip = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        gate = 1'b1;
        if (eof) begin
          gate      = 1'b0;
          inc_cap   = 1'b1;
          state_nxt = S_READOUT;
        end
      end
      S_READOUT: begin
        inc_ovr = sof;
        if (readout_done) begin
          if ((cfg_num_frames != '0) && (captured_count == cfg_num_frames))
            state_nxt = S_DONE;
          else if (!cfg_enable)
            state_nxt = S_IDLE;
          else
            state_nxt = S_WAIT_SOF;
        end
`ifdef HISTO_SEQ_TIMEOUT_EN
        else if (wd_cnt == TIMEOUT_CYC - 1) begin
          timeout_fire = 1'b1;
          state_nxt    = cfg_enable ? S_WAIT_SOF : S_IDLE;
        end
`endif
      end
      S_DONE: begin
        if (!cfg_enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      fv_q              <= 1'b0;
      frame_id          <= '0;
      skip_cnt          <= '0;
      capture_id        <= '0;
      captured_count    <= '0;
      skipped_count     <= '0;
      overrun_count     <= '0;
      histo_frame_valid <= 1'b0;
      histo_line_valid  <= 1'b0;
    end else begin
      state             <= state_nxt;
      fv_q              <= frame_valid;
      histo_frame_valid <= frame_valid & gate;
      histo_line_valid  <= line_valid & gate;
      if (sof && cfg_enable) frame_id <= frame_id_inc;
      if (clr_run) begin
        captured_count <= '0;
        skipped_count  <= '0;
        overrun_count  <= '0;
        skip_cnt       <= '0;
      end
      if (start_cap) begin
        capture_id <= frame_id_inc;
        skip_cnt   <= cfg_decimate;
      end
      if (skip_dec) skip_cnt <= skip_cnt - ONE_D;
      if (inc_skip && (skipped_count != '1)) skipped_count <= skipped_count + ONE_C;
      if (inc_cap && (captured_count != '1)) captured_count <= captured_count + ONE_C;
      if (inc_ovr && (overrun_count != '1)) overrun_count <= overrun_count + ONE_C;
    end
  end

`ifdef HISTO_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wd_cnt <= (state == S_READOUT) ? wd_cnt + 32'd1 : 32'd0;
      if (clr_run)
        timeout_flag <= 1'b0;
      else if (timeout_fire)
        timeout_flag <= 1'b1;
    end
  end
`endif

endmodule
